// File: rtl/tile_pixel_if.sv
// Pixel request/result handshake bundle for tile_pixel_pipe.
// Master drives requests and accepts results; slave is the pipeline.
interface tile_pixel_if #(
  parameter int unsigned TILE_BITS = 3,
  parameter int unsigned COLOR_W   = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_num;
  logic [TILE_BITS-1:0] in_x;
  logic [TILE_BITS-1:0] in_y;
  logic                 out_valid;
  logic                 out_ready;
  logic [COLOR_W-1:0]   out_data;

  modport master (
    output in_valid, in_num, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_num, in_x, in_y, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tile_pixel_pipe.sv
// Two-stage tile pixel shader: palette lookup (S1), pattern select (S2).
// Flash mode and the frame blink counter exist only with TILE_PIXEL_FLASH_EN.
module tile_pixel_pipe #(
  parameter int unsigned TILE_BITS    = 3,
  parameter int unsigned COLOR_W      = 12,
  parameter int unsigned BLINK_PERIOD = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  tile_pixel_if.slave        bus,
  input  logic               frame_start,
  input  logic               pal_we,
  input  logic [4:0]         pal_addr,
  input  logic [COLOR_W-1:0] pal_wdata
);

  localparam int unsigned PAL_N   = 32;
  localparam int unsigned TILE_N  = 1 << TILE_BITS;
  localparam int unsigned Y_SPLIT = TILE_N * 5 / 8;
  localparam int unsigned BG_IDX  = 9;

  localparam logic [1:0] MODE_SOLID  = 2'b00;
  localparam logic [1:0] MODE_BOTTOM = 2'b01;
  localparam logic [1:0] MODE_BORDER = 2'b10;
  localparam logic [1:0] MODE_FLASH  = 2'b11;

  localparam logic [TILE_BITS-1:0] Y_SPLIT_T = TILE_BITS'(Y_SPLIT);
  localparam logic [TILE_BITS-1:0] EDGE_LO   = TILE_BITS'(2);
  localparam logic [TILE_BITS-1:0] EDGE_HI   = TILE_BITS'(TILE_N - 2);
  localparam logic [COLOR_W-1:0]   MAGENTA   = COLOR_W'(12'hF0F);

  function automatic logic [COLOR_W-1:0] pal_default(input int unsigned i);
    logic [11:0] c;
    case (i)
      0:  c = 12'h4AD;  1:  c = 12'hB5A;  2:  c = 12'hFD3;  3:  c = 12'h18B;
      4:  c = 12'hE93;  5:  c = 12'h6C5;  6:  c = 12'hE64;  7:  c = 12'h666;
      8:  c = 12'h666;  9:  c = 12'hFFE;  10: c = 12'hEED;  11: c = 12'h4DF;
      12: c = 12'hE6D;  13: c = 12'hFF5;  14: c = 12'h1AF;  15: c = 12'hFB6;
      16: c = 12'h8E8;  17: c = 12'hF98;
      default: c = 12'hF0F;
    endcase
    return COLOR_W'(c);
  endfunction

  logic [COLOR_W-1:0]   pal [PAL_N];
  logic                 rdy_en;
  logic                 s1_valid;
  logic [COLOR_W-1:0]   s1_fg;
  logic [COLOR_W-1:0]   s1_bg;
  logic [TILE_BITS-1:0] s1_x;
  logic [TILE_BITS-1:0] s1_y;
  logic [1:0]           s1_mode;
  logic                 s1_rsv;
  logic                 s1_adv_c;
  logic                 fg_hit_c;
  logic [COLOR_W-1:0]   pix_c;

  // Palette: reads in the same cycle as a write see the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PAL_N; i++) pal[i] <= pal_default(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

`ifdef TILE_PIXEL_FLASH_EN
  localparam int unsigned CNT_W = $clog2(BLINK_PERIOD);

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blink_cnt <= '0;
    else if (frame_start)
      blink_cnt <= (blink_cnt == CNT_W'(BLINK_PERIOD - 1)) ? '0 : blink_cnt + CNT_W'(1);
  end

  assign blink_phase = (blink_cnt >= CNT_W'(BLINK_PERIOD / 2));
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  assign s1_adv_c     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = rdy_en && (!s1_valid || s1_adv_c);

  // S1: capture request with fg/bg colours looked up from the palette.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      s1_valid <= 1'b0;
      s1_fg    <= '0;
      s1_bg    <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_mode  <= MODE_SOLID;
      s1_rsv   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (bus.in_ready) begin
        s1_valid <= bus.in_valid;
        s1_fg    <= pal[bus.in_num[4:0]];
        s1_bg    <= pal[BG_IDX];
        s1_x     <= bus.in_x;
        s1_y     <= bus.in_y;
        s1_mode  <= bus.in_num[7:6];
        s1_rsv   <= bus.in_num[5];
      end
    end
  end

  // Pattern select; flash phase is the one current as the pixel enters S2.
  always_comb begin
    fg_hit_c = 1'b1;
    case (s1_mode)
      MODE_SOLID:  fg_hit_c = 1'b1;
      MODE_BOTTOM: fg_hit_c = (s1_y >= Y_SPLIT_T);
      MODE_BORDER: fg_hit_c = (s1_x < EDGE_LO) || (s1_x >= EDGE_HI) ||
                              (s1_y < EDGE_LO) || (s1_y >= EDGE_HI);
`ifdef TILE_PIXEL_FLASH_EN
      MODE_FLASH:  fg_hit_c = !blink_phase;
`else
      MODE_FLASH:  fg_hit_c = 1'b1;
`endif
      default:     fg_hit_c = 1'b1;
    endcase
    pix_c = s1_rsv ? MAGENTA : (fg_hit_c ? s1_fg : s1_bg);
  end

  // S2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (s1_adv_c) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) bus.out_data <= pix_c;
    end
  end

endmodule

// File: tb/tb_tile_pixel_pipe.sv
// Directed + randomized bench for tile_pixel_pipe, scoreboard from the pixel rules.
// Flash expectations follow TILE_PIXEL_FLASH_EN as defined for the build.
module tb_tile_pixel_pipe;
  localparam int unsigned TB = 3;
  localparam int unsigned CW = 12;
  localparam int unsigned BP = 32;
  localparam int unsigned N  = 1 << TB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pal_we = 1'b0;
  logic [4:0]    pal_addr = '0;
  logic [CW-1:0] pal_wdata = '0;

  always #5 clk = ~clk;

  tile_pixel_if #(.TILE_BITS(TB), .COLOR_W(CW)) bus ();

  tile_pixel_pipe #(.TILE_BITS(TB), .COLOR_W(CW), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .frame_start(frame_start),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata)
  );

  typedef struct { logic [CW-1:0] data; int cyc; } exp_t;

  int            vectors = 0;
  int            errors  = 0;
  int            cyc     = 0;
  bit            started = 0;
  bit            strict_lat = 0;
  bit            last_acc = 0;
  bit            hold_pend = 0;
  bit            saw_busy = 0;
  logic [CW-1:0] hold_data;
  exp_t          q[$];
  logic [CW-1:0] got[$];
  logic [CW-1:0] mpal [32];
  int            mcnt = 0;

  function automatic logic [CW-1:0] pal_def(input int i);
    case (i)
      0: return 12'h4AD;  1: return 12'hB5A;  2: return 12'hFD3;  3: return 12'h18B;
      4: return 12'hE93;  5: return 12'h6C5;  6: return 12'hE64;  7: return 12'h666;
      8: return 12'h666;  9: return 12'hFFE;  10: return 12'hEED; 11: return 12'h4DF;
      12: return 12'hE6D; 13: return 12'hFF5; 14: return 12'h1AF; 15: return 12'hFB6;
      16: return 12'h8E8; 17: return 12'hF98;
      default: return 12'hF0F;
    endcase
  endfunction

  // Reference pixel: plain rules on integers, phase from the frame count.
  function automatic logic [CW-1:0] exp_pix(input logic [7:0] num, input int x, input int y);
    logic [CW-1:0] fg, bg;
    bit hit;
    if (num[5]) return 12'hF0F;
    fg = mpal[num[4:0]];
    bg = mpal[9];
    case (num[7:6])
      2'b01:   hit = (y > int'(N * 5 / 8) - 1);
      2'b10:   hit = (x <= 1 || x >= int'(N) - 2 || y <= 1 || y >= int'(N) - 2);
`ifdef TILE_PIXEL_FLASH_EN
      2'b11:   hit = !(mcnt >= int'(BP / 2));
`endif
      default: hit = 1;
    endcase
    return hit ? fg : bg;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mpal[i] = pal_def(i);
    mcnt = 0;
    q.delete();
    hold_pend = 0;
    started = 0;
  endtask

  // One clock: sample 3ns before the edge, update the model, advance.
  task automatic cycle();
    bit fire;
    exp_t e;
    #6;
    if (hold_pend) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, hold_data);
    end
    hold_pend = bus.out_valid && !bus.out_ready;
    hold_data = bus.out_data;
    check("in_ready", bus.in_ready, started && (q.size() < 2 || bus.out_ready));
    if (!bus.in_ready) saw_busy = 1;
    if (bus.out_valid) check("no_dup", q.size() > 0, 1);
    last_acc = bus.in_valid && bus.in_ready;
    fire = bus.out_valid && bus.out_ready;
    if (fire && q.size() > 0) begin
      e = q.pop_front();
      check("pixel", bus.out_data, e.data);
      if (strict_lat) check("latency", cyc - e.cyc, 2);
      got.push_back(bus.out_data);
    end
    if (last_acc) begin
      e.data = exp_pix(bus.in_num, int'(bus.in_x), int'(bus.in_y));
      e.cyc  = cyc;
      q.push_back(e);
    end
    if (pal_we) mpal[pal_addr] = pal_wdata;
`ifdef TILE_PIXEL_FLASH_EN
    if (frame_start) mcnt = (mcnt + 1) % int'(BP);
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [7:0] num, input int x, input int y);
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    bus.in_x     = TB'(x);
    bus.in_y     = TB'(y);
    last_acc = 0;
    for (int i = 0; i < 20 && !last_acc; i++) cycle();
    if (!last_acc) check("accept_timeout", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) cycle();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic expect_got(input string tag, input int i, input logic [CW-1:0] v);
    if (got.size() > i) check(tag, got[i], v);
    else check({tag, "_missing"}, got.size(), i + 1);
  endtask

  // Assert reset (asynchronously, mid-cycle), check outputs, release.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", bus.in_ready, 0);
    @(posedge clk);
    #1;
    started = 1;
    check("ready_after_edge", bus.in_ready, 1);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      cycle();
      frame_start = 1'b0;
    end
  endtask

  task automatic flash_case(input string tag, input logic [CW-1:0] v);
    got.delete();
    send(8'hC6, 0, 0);
    drain();
    expect_got(tag, 0, v);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_num = '0; bus.in_x = '0; bus.in_y = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Reset palette, two-cycle latency, single-cycle valid pulse
    strict_lat = 1;
    got.delete();
    send(8'h00, 0, 0);
    check("lat_c1_valid", bus.out_valid, 0);
    cycle();
    check("lat_c2_valid", bus.out_valid, 1);
    check("lat_c2_data", bus.out_data, 12'h4AD);
    cycle();
    check("lat_c3_valid", bus.out_valid, 0);
    expect_got("solid0", 0, 12'h4AD);

    // Bottom half split
    got.delete();
    send(8'h4B, 0, 4);
    send(8'h4B, 0, 5);
    drain();
    expect_got("bottom_y4", 0, 12'hFFE);
    expect_got("bottom_y5", 1, 12'h4DF);

    // Border band
    got.delete();
    send(8'h82, 3, 3);
    send(8'h82, 6, 3);
    send(8'h82, 0, 7);
    drain();
    expect_got("border_3_3", 0, 12'hFFE);
    expect_got("border_6_3", 1, 12'hFD3);
    expect_got("border_0_7", 2, 12'hFD3);
    strict_lat = 0;

    // Back-pressure mid-stream
    got.delete();
    saw_busy = 0;
    begin
      int k = 0;
      logic [7:0] nums [4];
      nums[0] = 8'h00; nums[1] = 8'h01; nums[2] = 8'h02; nums[3] = 8'h03;
      for (int t = 0; t < 20; t++) begin
        bus.in_valid  = (k < 4);
        bus.in_num    = nums[k < 4 ? k : 3];
        bus.out_ready = !(t >= 2 && t < 5);
        cycle();
        if (last_acc) k++;
      end
      bus.in_valid = 1'b0;
      check("bp_all_accepted", k, 4);
    end
    drain();
    check("bp_ready_low_seen", saw_busy, 1);
    expect_got("bp_0", 0, 12'h4AD);
    expect_got("bp_1", 1, 12'hB5A);
    expect_got("bp_2", 2, 12'hFD3);
    expect_got("bp_3", 3, 12'h18B);

    // Palette write in the same cycle as the lookup of that entry
    got.delete();
    pal_we = 1'b1; pal_addr = 5'd2; pal_wdata = 12'h123;
    send(8'h02, 0, 0);
    pal_we = 1'b0;
    send(8'h02, 0, 0);
    drain();
    expect_got("collide_old", 0, 12'hFD3);
    expect_got("collide_new", 1, 12'h123);

    // Reserved bit forces magenta
    got.delete();
    send(8'hA2, 3, 3);
    drain();
    expect_got("reserved", 0, 12'hF0F);

    // Flash across frame counts
    flash_case("flash_0", 12'hE64);
    frames(16);
`ifdef TILE_PIXEL_FLASH_EN
    flash_case("flash_16", 12'hFFE);
`else
    flash_case("flash_16", 12'hE64);
`endif
    frames(16);
    flash_case("flash_32", 12'hE64);

    // Randomized traffic with back-pressure and palette writes
    for (int t = 0; t < 400; t++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_num    = 8'($urandom);
      bus.in_x      = TB'($urandom);
      bus.in_y      = TB'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      pal_we        = ($urandom_range(0, 9) == 0);
      pal_addr      = 5'($urandom);
      pal_wdata     = CW'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    pal_we = 1'b0;
    drain();

    // Reset with pixels in flight; palette returns to defaults
    bus.out_ready = 1'b0;
    send(8'h00, 0, 0);
    send(8'h01, 0, 0);
    do_reset();
    bus.out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 4; i++) cycle();
    check("flush_no_output", got.size(), 0);
    send(8'h02, 0, 0);
    drain();
    expect_got("post_reset_pal", 0, 12'hFD3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
